// File: rtl/game_display_timing_if.sv
// Video timing bundle driven by game_display_timing.
// line_stb exists only when GAME_DISPLAY_TIMING_LINE_STB_EN is defined.
interface game_display_timing_if #(
    parameter int unsigned SX_W = 8,
    parameter int unsigned SY_W = 9
);
    logic            hsync;
    logic            vsync;
    logic            vga_de;
    logic            display_enabled;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;
    logic            game_pix_stb;
    logic            frame_stb;
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
    logic            line_stb;
`endif

    modport master (
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
        output line_stb,
`endif
        output hsync, vsync, vga_de, display_enabled, sx, sy, game_pix_stb, frame_stb
    );

    modport slave (
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
        input line_stb,
`endif
        input hsync, vsync, vga_de, display_enabled, sx, sy, game_pix_stb, frame_stb
    );
endinterface

// File: rtl/game_display_timing.sv
// VGA raster timing with a scaled virtual game window; every output registered, 1-cycle latency.
// Optional feature macro: GAME_DISPLAY_TIMING_LINE_STB_EN adds line_stb (one pulse per game row).
module game_display_timing #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BACK    = 88,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FRONT   = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BACK    = 23,
    parameter int unsigned GAME_W    = 224,
    parameter int unsigned GAME_H    = 288,
    parameter int unsigned SCALE     = 2,
    parameter int unsigned H_OFFSET  = 176,
    parameter int unsigned V_OFFSET  = 12
) (
    input  logic                  vga_pix_clk,
    input  logic                  rst,
    game_display_timing_if.master vid
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HC_W    = $clog2(H_TOTAL);
    localparam int unsigned VC_W    = $clog2(V_TOTAL);
    localparam int unsigned SX_W    = (GAME_W > 1) ? $clog2(GAME_W) : 1;
    localparam int unsigned SY_W    = (GAME_H > 1) ? $clog2(GAME_H) : 1;
    localparam int unsigned SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_DE_END = HC_W'(H_VISIBLE);
    localparam logic [HC_W-1:0] HS_FIRST = HC_W'(H_VISIBLE + H_FRONT);
    localparam logic [HC_W-1:0] HS_LAST  = HC_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [HC_W-1:0] HW_FIRST = HC_W'(H_OFFSET);
    localparam logic [HC_W-1:0] HW_LAST  = HC_W'(H_OFFSET + GAME_W * SCALE - 1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_DE_END = VC_W'(V_VISIBLE);
    localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_VISIBLE + V_FRONT);
    localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [VC_W-1:0] VW_FIRST = VC_W'(V_OFFSET);
    localparam logic [VC_W-1:0] VW_LAST  = VC_W'(V_OFFSET + GAME_H * SCALE - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

    // Game window must fit inside the visible raster.
    if ((GAME_W * SCALE + H_OFFSET > H_VISIBLE) || (GAME_H * SCALE + V_OFFSET > V_VISIBLE)) begin : g_bad_window
        $fatal(1, "game_display_timing: game window exceeds visible area");
    end

    logic [HC_W-1:0]  hcount, hcount_n;
    logic [VC_W-1:0]  vcount, vcount_n;
    logic [SUB_W-1:0] hsub, hsub_n, vsub, vsub_n;
    logic [SX_W-1:0]  gx, gx_n;
    logic [SY_W-1:0]  gy, gy_n;
    logic             h_last, v_last, in_h, in_v, win, pix;

    // Next raster position; sub-pixel/game counters describe the current position and idle at 0 outside the window.
    always_comb begin
        h_last   = (hcount == H_LAST);
        v_last   = (vcount == V_LAST);
        in_h     = (hcount >= HW_FIRST) && (hcount <= HW_LAST);
        in_v     = (vcount >= VW_FIRST) && (vcount <= VW_LAST);
        win      = in_h && in_v;
        pix      = win && (hsub == '0) && (vsub == '0);
        hcount_n = h_last ? '0 : hcount + HC_W'(1);
        vcount_n = vcount;
        hsub_n   = '0;
        gx_n     = '0;
        vsub_n   = vsub;
        gy_n     = gy;
        if (in_h && (hcount != HW_LAST)) begin
            if (hsub == SUB_LAST) begin
                gx_n = gx + SX_W'(1);
            end else begin
                hsub_n = hsub + SUB_W'(1);
                gx_n   = gx;
            end
        end
        if (h_last) begin
            vcount_n = v_last ? '0 : vcount + VC_W'(1);
            vsub_n   = '0;
            gy_n     = '0;
            if (in_v && (vcount != VW_LAST)) begin
                if (vsub == SUB_LAST) begin
                    gy_n = gy + SY_W'(1);
                end else begin
                    vsub_n = vsub + SUB_W'(1);
                    gy_n   = gy;
                end
            end
        end
    end

    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            hcount              <= '0;
            vcount              <= '0;
            hsub                <= '0;
            vsub                <= '0;
            gx                  <= '0;
            gy                  <= '0;
            vid.hsync           <= 1'b0;
            vid.vsync           <= 1'b0;
            vid.vga_de          <= 1'b0;
            vid.display_enabled <= 1'b0;
            vid.sx              <= '0;
            vid.sy              <= '0;
            vid.game_pix_stb    <= 1'b0;
            vid.frame_stb       <= 1'b0;
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
            vid.line_stb        <= 1'b0;
`endif
        end else begin
            hcount              <= hcount_n;
            vcount              <= vcount_n;
            hsub                <= hsub_n;
            vsub                <= vsub_n;
            gx                  <= gx_n;
            gy                  <= gy_n;
            vid.hsync           <= (hcount >= HS_FIRST) && (hcount <= HS_LAST);
            vid.vsync           <= (vcount >= VS_FIRST) && (vcount <= VS_LAST);
            vid.vga_de          <= (hcount < H_DE_END) && (vcount < V_DE_END);
            vid.display_enabled <= win;
            vid.sx              <= win ? gx : '0;
            vid.sy              <= win ? gy : '0;
            vid.game_pix_stb    <= pix;
            vid.frame_stb       <= (hcount == '0) && (vcount == '0);
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
            vid.line_stb        <= pix && (gx == '0);
`endif
        end
    end
endmodule

// File: tb/tb_game_display_timing.sv
// Randomized-reset bench for game_display_timing on a reduced raster, checked against a position-based model.
module tb_game_display_timing;
    localparam int H_VISIBLE = 48, H_FRONT = 4, H_SYNC = 8, H_BACK = 4;
    localparam int V_VISIBLE = 50, V_FRONT = 1, V_SYNC = 4, V_BACK = 3;
    localparam int GAME_W = 14, GAME_H = 15, SCALE = 3, H_OFFSET = 4, V_OFFSET = 3;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int SX_W    = $clog2(GAME_W);
    localparam int SY_W    = $clog2(GAME_H);

    typedef struct {
        logic hs, vs, de, win, pix, frm, line;
        int   sx, sy;
    } exp_t;

    logic vga_pix_clk;
    logic rst;
    int   n_checks, n_fail;
    int   pos;
    logic clean;
    int   interval, cnt_pix, cnt_win, cnt_line, n_full;
    int   run_hs, run_vs, run_de;
    int   first_idx, first_sx, first_sy, last_idx, last_sx, last_sy;

    game_display_timing_if #(.SX_W(SX_W), .SY_W(SY_W)) vid ();

    game_display_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .GAME_W(GAME_W), .GAME_H(GAME_H), .SCALE(SCALE), .H_OFFSET(H_OFFSET), .V_OFFSET(V_OFFSET)
    ) dut (
        .vga_pix_clk(vga_pix_clk),
        .rst(rst),
        .vid(vid)
    );

    initial vga_pix_clk = 1'b0;
    always #5 vga_pix_clk = ~vga_pix_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs expected one cycle after the counters sat at raster position p (cycles since frame start).
    function automatic exp_t model(input int p);
        exp_t m;
        int   h, v;
        h     = p % H_TOTAL;
        v     = p / H_TOTAL;
        m.hs  = (h >= H_VISIBLE + H_FRONT) && (h < H_VISIBLE + H_FRONT + H_SYNC);
        m.vs  = (v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC);
        m.de  = (h < H_VISIBLE) && (v < V_VISIBLE);
        m.win = (h >= H_OFFSET) && (h < H_OFFSET + GAME_W * SCALE) &&
                (v >= V_OFFSET) && (v < V_OFFSET + GAME_H * SCALE);
        m.sx  = m.win ? (h - H_OFFSET) / SCALE : 0;
        m.sy  = m.win ? (v - V_OFFSET) / SCALE : 0;
        m.pix = m.win && ((h - H_OFFSET) % SCALE == 0) && ((v - V_OFFSET) % SCALE == 0);
        m.frm = (p == 0);
        m.line = m.pix && (m.sx == 0);
        return m;
    endfunction

    task automatic clear_frame_stats();
        interval  = 0;
        cnt_pix   = 0;
        cnt_win   = 0;
        cnt_line  = 0;
        first_idx = -1;
        first_sx  = 0;
        first_sy  = 0;
        last_idx  = -1;
        last_sx   = 0;
        last_sy   = 0;
    endtask

    task automatic end_run(input string tag, inout int run, input logic level, input int want);
        if (level) begin
            run++;
        end else if (run > 0) begin
            check(tag, run, want);
            run = 0;
        end
    endtask

    // One clock: drive rst, advance the model, compare every output, gather frame statistics.
    task automatic step(input logic r);
        exp_t e;
        logic ln;
        rst = r;
        @(posedge vga_pix_clk);
        #1;
        if (r) begin
            e   = '{default: 0};
            pos = 0;
        end else begin
            e   = model(pos);
            pos = (pos + 1) % FRAME;
        end
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
        ln = vid.line_stb;
        check("line_stb", ln, e.line);
`else
        ln = e.line;
`endif
        check("hsync", vid.hsync, e.hs);
        check("vsync", vid.vsync, e.vs);
        check("vga_de", vid.vga_de, e.de);
        check("display_enabled", vid.display_enabled, e.win);
        check("sx", vid.sx, e.sx);
        check("sy", vid.sy, e.sy);
        check("game_pix_stb", vid.game_pix_stb, e.pix);
        check("frame_stb", vid.frame_stb, e.frm);
        if (r) begin
            clean  = 1'b0;
            run_hs = 0;
            run_vs = 0;
            run_de = 0;
            clear_frame_stats();
        end else begin
            if (vid.frame_stb) begin
                if (clean) begin
                    n_full++;
                    check("frame_interval", interval, FRAME);
                    check("pix_count", cnt_pix, GAME_W * GAME_H);
                    check("window_cycles", cnt_win, GAME_W * GAME_H * SCALE * SCALE);
                    check("first_pix_idx", first_idx, V_OFFSET * H_TOTAL + H_OFFSET);
                    check("first_pix_sx", first_sx, 0);
                    check("first_pix_sy", first_sy, 0);
                    check("last_pix_idx", last_idx,
                          (V_OFFSET + (GAME_H - 1) * SCALE) * H_TOTAL + H_OFFSET + (GAME_W - 1) * SCALE);
                    check("last_pix_sx", last_sx, GAME_W - 1);
                    check("last_pix_sy", last_sy, GAME_H - 1);
`ifdef GAME_DISPLAY_TIMING_LINE_STB_EN
                    check("line_count", cnt_line, GAME_H);
`endif
                end
                clear_frame_stats();
                clean = 1'b1;
            end
            if (vid.game_pix_stb) begin
                cnt_pix++;
                if (first_idx < 0) begin
                    first_idx = interval;
                    first_sx  = int'(vid.sx);
                    first_sy  = int'(vid.sy);
                end
                last_idx = interval;
                last_sx  = int'(vid.sx);
                last_sy  = int'(vid.sy);
            end
            if (vid.display_enabled) cnt_win++;
            if (ln) cnt_line++;
            interval++;
            end_run("hsync_width", run_hs, vid.hsync, H_SYNC);
            end_run("vsync_width", run_vs, vid.vsync, V_SYNC * H_TOTAL);
            end_run("de_width", run_de, vid.vga_de, H_VISIBLE);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        n_checks = 0;
        n_fail   = 0;
        n_full   = 0;
        pos      = 0;
        clean    = 1'b0;
        run_hs   = 0;
        run_vs   = 0;
        run_de   = 0;
        clear_frame_stats();

        // Five reset cycles; the cycle after release shows counters at (0,0), frame_stb one cycle later.
        for (int i = 0; i < 5; i++) step(1'b1);
        check("rel_cycle1_frame_stb", vid.frame_stb, 1'b0);
        step(1'b0);
        check("rel_cycle2_frame_stb", vid.frame_stb, 1'b1);
        run(2 * FRAME + 10);

        // One-cycle reset in the middle of a line halfway down the visible area.
        while (pos != (V_VISIBLE / 2) * H_TOTAL + H_TOTAL / 2) step(1'b0);
        step(1'b1);
        step(1'b0);
        check("midreset_frame_stb", vid.frame_stb, 1'b1);
        run(2 * FRAME + 5);

        // Random reset pulses at random raster positions.
        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(1, FRAME)));
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'b1);
        end
        run(2 * FRAME + 5);

        check("full_frames_seen", (n_full >= 4) ? 32'd1 : 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
